// File: rtl/onehot_event_scheduler.sv
// Event capture and round-robin one-hot issue stage feeding the 8-to-3 encoder.
// Sticky pending flags are drained one grant at a time through a valid/ready output register.
module onehot_event_scheduler #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] evt_in,
    input  logic         clr_all,
    output logic [N-1:0] onehot_out,
    output logic         valid_out,
    input  logic         ready_in,
    output logic [N-1:0] pending,
    output logic [N-1:0] overflow
);

    localparam int unsigned PW = $clog2(N);

    logic [N-1:0]  pending_q,  pending_d;
    logic [N-1:0]  overflow_q, overflow_d;
    logic [N-1:0]  onehot_q,   onehot_d;
    logic          valid_q,    valid_d;
    logic [PW-1:0] ptr_q,      ptr_d;

    logic          stage_free;
    logic          found;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] idx;
    logic          load;
    logic [N-1:0]  load_mask;

    assign stage_free = !valid_q || ready_in;

    // N is a power of two, so PW-bit addition wraps the search index modulo N.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr_q + PW'(k);
            if (!found && pending_q[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign load      = stage_free && found;
    assign load_mask = load ? (N'(1) << grant_idx) : '0;

    always_comb begin
        pending_d  = (pending_q & ~load_mask) | evt_in;
        overflow_d = overflow_q | (evt_in & pending_q & ~load_mask);
        onehot_d   = onehot_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        if (stage_free) begin
            onehot_d = load_mask;
            valid_d  = load;
        end
        if (load) begin
            ptr_d = grant_idx + PW'(1);
        end
        if (clr_all) begin
            pending_d  = '0;
            overflow_d = '0;
            onehot_d   = '0;
            valid_d    = 1'b0;
            ptr_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= '0;
            onehot_q   <= '0;
            valid_q    <= 1'b0;
            ptr_q      <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            onehot_q   <= onehot_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign onehot_out = onehot_q;
    assign valid_out  = valid_q;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_onehot_event_scheduler.sv
// Directed bench for onehot_event_scheduler: hand-computed vector table plus an async-reset sequence.
module tb_onehot_event_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] evt_in;
    logic       clr_all;
    logic [7:0] onehot_out;
    logic       valid_out;
    logic       ready_in;
    logic [7:0] pending;
    logic [7:0] overflow;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] evt;
        logic       clr;
        logic       rdy;
        logic [7:0] oh;
        logic       v;
        logic [7:0] pend;
        logic [7:0] ovf;
    } vec_t;

    vec_t tv[$];

    onehot_event_scheduler #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evt_in     (evt_in),
        .clr_all    (clr_all),
        .onehot_out (onehot_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .pending    (pending),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] oh, input logic v,
                           input logic [7:0] pend, input logic [7:0] ovf);
        chk({tag, " onehot"},   onehot_out, oh);
        chk({tag, " valid"},    {7'd0, valid_out}, {7'd0, v});
        chk({tag, " pending"},  pending, pend);
        chk({tag, " overflow"}, overflow, ovf);
    endtask

    // Drive inputs, advance one rising edge, sample 1 time unit later.
    task automatic step(input logic [7:0] e, input logic c, input logic r);
        evt_in   = e;
        clr_all  = c;
        ready_in = r;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [7:0] e, input logic c, input logic r,
                                input logic [7:0] oh, input logic v,
                                input logic [7:0] pend, input logic [7:0] ovf);
        vec_t t;
        t.evt = e; t.clr = c; t.rdy = r;
        t.oh = oh; t.v = v; t.pend = pend; t.ovf = ovf;
        tv.push_back(t);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (valid_out ? !$onehot(onehot_out) : (onehot_out != 8'h00)) begin
                errors++;
                $display("FAIL onehot_invariant: got onehot=%h valid=%b required one-hot iff valid",
                         onehot_out, valid_out);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        evt_in   = '0;
        clr_all  = 1'b0;
        ready_in = 1'b0;

        //                evt  clr rdy  oh   v  pend  ovf
        // single event, 2-edge latency, one-cycle valid
        add(8'h10, 0, 1, 8'h00, 0, 8'h10, 8'h00);
        add(8'h00, 0, 1, 8'h10, 1, 8'h00, 8'h00);
        add(8'h00, 0, 1, 8'h00, 0, 8'h00, 8'h00);
        // round-robin from ptr=1 over 0x85
        add(8'h01, 0, 1, 8'h00, 0, 8'h01, 8'h00);
        add(8'h00, 0, 1, 8'h01, 1, 8'h00, 8'h00);
        add(8'h85, 0, 1, 8'h00, 0, 8'h85, 8'h00);
        add(8'h00, 0, 1, 8'h04, 1, 8'h81, 8'h00);
        add(8'h00, 0, 1, 8'h80, 1, 8'h01, 8'h00);
        add(8'h00, 0, 1, 8'h01, 1, 8'h00, 8'h00);
        add(8'h00, 0, 1, 8'h00, 0, 8'h00, 8'h00);
        // backpressure and overflow
        add(8'h01, 0, 0, 8'h00, 0, 8'h01, 8'h00);
        add(8'h00, 0, 0, 8'h01, 1, 8'h00, 8'h00);
        add(8'h02, 0, 0, 8'h01, 1, 8'h02, 8'h00);
        add(8'h00, 0, 0, 8'h01, 1, 8'h02, 8'h00);
        add(8'h02, 0, 0, 8'h01, 1, 8'h02, 8'h02);
        add(8'h01, 0, 0, 8'h01, 1, 8'h03, 8'h02);
        add(8'h00, 0, 1, 8'h02, 1, 8'h01, 8'h02);
        add(8'h00, 0, 1, 8'h01, 1, 8'h00, 8'h02);
        add(8'h00, 0, 1, 8'h00, 0, 8'h00, 8'h02);
        // clear, then event on the bit being loaded is retained
        add(8'h00, 1, 1, 8'h00, 0, 8'h00, 8'h00);
        add(8'h08, 0, 1, 8'h00, 0, 8'h08, 8'h00);
        add(8'h08, 0, 1, 8'h08, 1, 8'h08, 8'h00);
        add(8'h00, 0, 1, 8'h08, 1, 8'h00, 8'h00);
        add(8'h00, 0, 1, 8'h00, 0, 8'h00, 8'h00);
        // clr_all wins over events and transfer, ptr back to 0
        add(8'h06, 0, 1, 8'h00, 0, 8'h06, 8'h00);
        add(8'h04, 0, 1, 8'h02, 1, 8'h04, 8'h04);
        add(8'hFF, 1, 1, 8'h00, 0, 8'h00, 8'h00);
        add(8'h81, 0, 1, 8'h00, 0, 8'h81, 8'h00);
        add(8'h00, 0, 1, 8'h01, 1, 8'h80, 8'h00);
        add(8'h00, 0, 1, 8'h80, 1, 8'h00, 8'h00);
        add(8'h00, 0, 1, 8'h00, 0, 8'h00, 8'h00);

        // power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_all("por", 8'h00, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;

        // async reset mid-transfer, then search restarts at bit 0
        step(8'h01, 1'b0, 1'b0);
        chk_all("rst_a", 8'h00, 1'b0, 8'h01, 8'h00);
        step(8'h0C, 1'b0, 1'b0);
        chk_all("rst_b", 8'h01, 1'b1, 8'h0C, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst_async", 8'h00, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
        step(8'h81, 1'b0, 1'b1);
        chk_all("rst_c", 8'h00, 1'b0, 8'h81, 8'h00);
        step(8'h00, 1'b0, 1'b1);
        chk_all("rst_ptr0", 8'h01, 1'b1, 8'h80, 8'h00);
        step(8'h00, 1'b0, 1'b1);
        chk_all("rst_d", 8'h80, 1'b1, 8'h00, 8'h00);
        step(8'h00, 1'b0, 1'b1);
        chk_all("rst_e", 8'h00, 1'b0, 8'h00, 8'h00);

        foreach (tv[i]) begin
            step(tv[i].evt, tv[i].clr, tv[i].rdy);
            chk_all($sformatf("vec%0d", i), tv[i].oh, tv[i].v, tv[i].pend, tv[i].ovf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
